fifo_wr_arbiter: RTL and testbench

- Shares one synchronous FIFO write port among N_REQ producers using round-robin arbitration with bounded burst ownership.
- Sits between producer blocks (valid/ready) and the FIFO's wr_en/din/full interface.
- One owner at a time; the owner streams up to MAX_BURST beats, then the grant rotates.

---
 rtl/fifo_wr_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 148 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types, defaults and width helpers for the FIFO write-port arbiter.
package fifo_wr_arb_pkg;

    localparam int unsigned DEF_N_REQ     = 4;
    localparam int unsigned DEF_WIDTH     = 16;
    localparam int unsigned DEF_MAX_BURST = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Index width for a requester id; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Beat counter width able to hold 0..max_burst.
    function automatic int unsigned cnt_width(input int unsigned max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping.
module rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = DEF_N_REQ,
    localparam int unsigned IDW   = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDW-1:0]   i_last,
    output logic [IDW-1:0]   o_winner,
    output logic             o_any_req
);

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        o_winner  = '0;
        o_any_req = |i_req;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            int idx;
            idx = int'(i_last) + k;
            if (idx >= int'(N_REQ)) begin
                idx = idx - int'(N_REQ);
            end
            if (i_req[IDW'(idx)]) begin
                o_winner = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port with bounded bursts per grant.
// Optional counters stall_cnt/beats_total enabled by FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter  int unsigned N_REQ     = DEF_N_REQ,
    parameter  int unsigned WIDTH     = DEF_WIDTH,
    parameter  int unsigned MAX_BURST = DEF_MAX_BURST,
    localparam int unsigned IDW       = id_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   fifo_full,
    output logic                   fifo_wr_en,
    output logic [WIDTH-1:0]       fifo_din,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [31:0]            stall_cnt,
    output logic [31:0]            beats_total
`endif
);

    localparam int unsigned    BCW       = cnt_width(MAX_BURST);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);
    localparam logic [0:0]     S_IDLE    = ST_IDLE;
    localparam logic [0:0]     S_GRANT   = ST_GRANT;

    logic [0:0]     r_state;
    logic [IDW-1:0] r_owner;
    logic [IDW-1:0] r_last_owner;
    logic [BCW-1:0] r_beat_cnt;

    logic [0:0]     w_state_nxt;
    logic [IDW-1:0] w_owner_nxt;
    logic [IDW-1:0] w_last_nxt;
    logic [BCW-1:0] w_beat_nxt;

    logic [IDW-1:0] w_pick_id;
    logic           w_any_req;
    logic           w_owner_valid;
    logic [WIDTH-1:0] w_owner_data;
    logic           w_in_grant;
    logic           w_xfer;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .i_req     (req_valid),
        .i_last    (r_last_owner),
        .o_winner  (w_pick_id),
        .o_any_req (w_any_req)
    );

    assign w_owner_valid = req_valid[r_owner];
    assign w_owner_data  = req_data[32'(r_owner) * WIDTH +: WIDTH];
    assign w_in_grant    = (r_state == S_GRANT);
    assign w_xfer        = w_in_grant & w_owner_valid & ~fifo_full;

    // Write-port outputs; masked while rst is low so an aborted burst never writes.
    always_comb begin
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        if (w_in_grant && rst) begin
            req_ready[r_owner] = ~fifo_full;
            fifo_wr_en         = w_xfer;
            fifo_din           = w_owner_data;
        end
    end

    // Next-state logic: arbitrate in IDLE, stream and release in GRANT.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last_owner;
        w_beat_nxt  = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_GRANT;
                    w_owner_nxt = w_pick_id;
                    w_beat_nxt  = '0;
                end
            end
            S_GRANT: begin
                // Dropped valid releases even during a full stall.
                if (!w_owner_valid || (w_xfer && (r_beat_cnt == LAST_BEAT))) begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = r_owner;
                end else if (w_xfer) begin
                    w_beat_nxt = r_beat_cnt + BCW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_owner      <= '0;
            r_last_owner <= IDW'(N_REQ - 1);
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_nxt;
            r_beat_cnt   <= w_beat_nxt;
        end
    end

    assign busy     = w_in_grant;
    assign grant_id = r_owner;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_beats_total;
    logic        w_stall;

    assign w_stall = w_in_grant & w_owner_valid & fifo_full;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt   <= '0;
            r_beats_total <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_xfer && (r_beats_total != '1)) begin
                r_beats_total <= r_beats_total + 32'd1;
            end
        end
    end

    assign stall_cnt   = r_stall_cnt;
    assign beats_total = r_beats_total;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-scenario tasks with a write scoreboard.
module tb_fifo_wr_arbiter;

    localparam int unsigned N_REQ     = 4;
    localparam int unsigned WIDTH     = 16;
    localparam int unsigned MAX_BURST = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   fifo_full;
    logic                   fifo_wr_en;
    logic [WIDTH-1:0]       fifo_din;
    logic [1:0]             grant_id;
    logic                   busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [31:0]            stall_cnt;
    logic [31:0]            beats_total;
`endif

    fifo_wr_arbiter #(
        .N_REQ     (N_REQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_din    (fifo_din),
        .grant_id    (grant_id),
        .busy        (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stall_cnt   (stall_cnt),
        .beats_total (beats_total)
`endif
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic        tb_rst;
    logic        tb_full;
    int          rem [N_REQ];
    int          seq [N_REQ];
    logic [15:0] sb_q [$];
    logic [15:0] exp_d;

    // One clock: drive producers after the edge, sample at negedge, retire accepted beats.
    task automatic step();
        @(posedge clk);
        #1;
        rst       = tb_rst;
        fifo_full = tb_full;
        for (int i = 0; i < int'(N_REQ); i++) begin
            req_valid[i]                = (rem[i] > 0);
            req_data[i*WIDTH +: WIDTH]  = {4'(i), 12'(seq[i])};
        end
        @(negedge clk);
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (req_valid[i] && req_ready[i]) begin
                rem[i]--;
                seq[i]++;
            end
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < int'(N_REQ); i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        sb_q.delete();
        tb_full = 1'b0;
        tb_rst  = 1'b0;
        step();
        tb_rst  = 1'b1;
    endtask

    task automatic push_beats(input int r, input int first, input int n);
        for (int s = first; s < first + n; s++) begin
            sb_q.push_back({4'(r), 12'(s)});
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < int'(N_REQ); i++) rem[i] = 5;
        tb_full = 1'b0;
        tb_rst  = 1'b0;
        step();
        step();
        n_assert++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b, required 0000", req_ready); end
        n_assert++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b, required 0", fifo_wr_en); end
        n_assert++; if (fifo_din !== 16'h0) begin n_fail++; $display("FAIL reset_din: got %h, required 0000", fifo_din); end
        n_assert++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d, required 0", grant_id); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
`ifdef FIFO_WR_ARB_STATS_EN
        n_assert++; if (stall_cnt !== 32'd0 || beats_total !== 32'd0) begin n_fail++; $display("FAIL reset_stats: got %0d/%0d, required 0/0", stall_cnt, beats_total); end
`endif
    endtask

    task automatic test_single_stream();
        logic [1:10] exp_busy = 10'b0111101110;
        logic [1:10] exp_wr   = 10'b0111101100;
        do_reset();
        rem[0] = 6;
        push_beats(0, 0, 6);
        for (int c = 1; c <= 10; c++) begin
            step();
            n_assert++; if (busy !== exp_busy[c]) begin n_fail++; $display("FAIL single_busy c%0d: got %b, required %b", c, busy, exp_busy[c]); end
            n_assert++; if (fifo_wr_en !== exp_wr[c]) begin n_fail++; $display("FAIL single_wr_en c%0d: got %b, required %b", c, fifo_wr_en, exp_wr[c]); end
            n_assert++; if (req_ready !== (exp_busy[c] ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL single_ready c%0d: got %b", c, req_ready); end
            if (exp_busy[c]) begin
                n_assert++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL single_grant c%0d: got %0d, required 0", c, grant_id); end
            end
            if (fifo_wr_en === 1'b1) begin
                n_assert++;
                if (sb_q.size() == 0) begin n_fail++; $display("FAIL single_data c%0d: unexpected write %h", c, fifo_din); end
                else begin
                    exp_d = sb_q.pop_front();
                    if (fifo_din !== exp_d) begin n_fail++; $display("FAIL single_data c%0d: got %h, required %h", c, fifo_din, exp_d); end
                end
            end
        end
        n_assert++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL single_drain: %0d beats never written, required 0", sb_q.size()); end
    endtask

    task automatic test_round_robin();
        int n_wr;
        logic exp_busy;
        logic [3:0] exp_rdy;
        int g;
        do_reset();
        n_wr = 0;
        for (int i = 0; i < int'(N_REQ); i++) rem[i] = 1000;
        for (int r = 0; r < 4; r++) push_beats(r, 0, 4);
        for (int c = 1; c <= 21; c++) begin
            step();
            exp_busy = (c % 5 != 1);
            g = (c - 2) / 5;
            exp_rdy = '0;
            if (exp_busy) exp_rdy[g] = 1'b1;
            n_assert++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rr_busy c%0d: got %b, required %b", c, busy, exp_busy); end
            n_assert++; if (fifo_wr_en !== exp_busy) begin n_fail++; $display("FAIL rr_wr_en c%0d: got %b, required %b", c, fifo_wr_en, exp_busy); end
            n_assert++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready c%0d: got %b, required %b", c, req_ready, exp_rdy); end
            if (exp_busy) begin
                n_assert++; if (grant_id !== 2'(g)) begin n_fail++; $display("FAIL rr_grant c%0d: got %0d, required %0d", c, grant_id, g); end
            end
            if (fifo_wr_en === 1'b1) begin
                n_wr++;
                n_assert++;
                if (sb_q.size() == 0) begin n_fail++; $display("FAIL rr_data c%0d: unexpected write %h", c, fifo_din); end
                else begin
                    exp_d = sb_q.pop_front();
                    if (fifo_din !== exp_d) begin n_fail++; $display("FAIL rr_data c%0d: got %h, required %h", c, fifo_din, exp_d); end
                end
            end
        end
        n_assert++; if (n_wr != 16) begin n_fail++; $display("FAIL rr_throughput: got %0d writes in 20 cycles, required 16", n_wr); end
        n_assert++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL rr_drain: %0d beats never written, required 0", sb_q.size()); end
    endtask

    task automatic test_full_stall();
        logic [1:13] exp_busy = 13'b0111111101110;
        logic [1:13] exp_wr   = 13'b0110001101100;
        logic [3:0] exp_rdy;
        int g;
        int n_wr;
        do_reset();
        n_wr = 0;
        rem[2] = 4;
        rem[3] = 2;
        push_beats(2, 0, 4);
        push_beats(3, 0, 2);
        for (int c = 1; c <= 13; c++) begin
            tb_full = (c >= 4 && c <= 6);
            step();
            g = (c <= 8) ? 2 : 3;
            exp_rdy = '0;
            if (exp_busy[c] && !tb_full) exp_rdy[g] = 1'b1;
            n_assert++; if (busy !== exp_busy[c]) begin n_fail++; $display("FAIL stall_busy c%0d: got %b, required %b", c, busy, exp_busy[c]); end
            n_assert++; if (fifo_wr_en !== exp_wr[c]) begin n_fail++; $display("FAIL stall_wr_en c%0d: got %b, required %b", c, fifo_wr_en, exp_wr[c]); end
            n_assert++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL stall_ready c%0d: got %b, required %b", c, req_ready, exp_rdy); end
            if (exp_busy[c]) begin
                n_assert++; if (grant_id !== 2'(g)) begin n_fail++; $display("FAIL stall_grant c%0d: got %0d, required %0d", c, grant_id, g); end
            end
            if (fifo_wr_en === 1'b1) begin
                n_wr++;
                n_assert++;
                if (sb_q.size() == 0) begin n_fail++; $display("FAIL stall_data c%0d: unexpected write %h", c, fifo_din); end
                else begin
                    exp_d = sb_q.pop_front();
                    if (fifo_din !== exp_d) begin n_fail++; $display("FAIL stall_data c%0d: got %h, required %h", c, fifo_din, exp_d); end
                end
            end
        end
        tb_full = 1'b0;
        n_assert++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL stall_drain: %0d beats never written, required 0", sb_q.size()); end
`ifdef FIFO_WR_ARB_STATS_EN
        n_assert++; if (stall_cnt !== 32'd3) begin n_fail++; $display("FAIL stats_stall: got %0d, required 3", stall_cnt); end
        n_assert++; if (beats_total !== 32'(n_wr) || n_wr != 6) begin n_fail++; $display("FAIL stats_beats: got %0d, required %0d (6)", beats_total, n_wr); end
`endif
    endtask

    task automatic test_owner_drop();
        logic [1:10] exp_busy = 10'b0111011110;
        logic [1:10] exp_wr   = 10'b0110011100;
        logic [3:0] exp_rdy;
        int g;
        do_reset();
        rem[1] = 2;
        rem[3] = 3;
        push_beats(1, 0, 2);
        push_beats(3, 0, 3);
        for (int c = 1; c <= 10; c++) begin
            step();
            g = (c <= 4) ? 1 : 3;
            exp_rdy = '0;
            if (exp_busy[c]) exp_rdy[g] = 1'b1;
            n_assert++; if (busy !== exp_busy[c]) begin n_fail++; $display("FAIL drop_busy c%0d: got %b, required %b", c, busy, exp_busy[c]); end
            n_assert++; if (fifo_wr_en !== exp_wr[c]) begin n_fail++; $display("FAIL drop_wr_en c%0d: got %b, required %b", c, fifo_wr_en, exp_wr[c]); end
            n_assert++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL drop_ready c%0d: got %b, required %b", c, req_ready, exp_rdy); end
            if (exp_busy[c]) begin
                n_assert++; if (grant_id !== 2'(g)) begin n_fail++; $display("FAIL drop_grant c%0d: got %0d, required %0d", c, grant_id, g); end
            end else begin
                n_assert++; if (fifo_din !== 16'h0) begin n_fail++; $display("FAIL drop_idle_din c%0d: got %h, required 0000", c, fifo_din); end
            end
            if (fifo_wr_en === 1'b1) begin
                n_assert++;
                if (sb_q.size() == 0) begin n_fail++; $display("FAIL drop_data c%0d: unexpected write %h", c, fifo_din); end
                else begin
                    exp_d = sb_q.pop_front();
                    if (fifo_din !== exp_d) begin n_fail++; $display("FAIL drop_data c%0d: got %h, required %h", c, fifo_din, exp_d); end
                end
            end
        end
        n_assert++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL drop_drain: %0d beats never written, required 0", sb_q.size()); end
    endtask

    task automatic test_reset_mid_burst();
        logic [1:10] exp_busy = 10'b0111011110;
        logic [1:10] exp_wr   = 10'b0110011110;
        do_reset();
        rem[0] = 8;
        rem[1] = 4;
        push_beats(0, 0, 6);
        for (int c = 1; c <= 10; c++) begin
            tb_rst = (c != 4);
            step();
            n_assert++; if (busy !== exp_busy[c]) begin n_fail++; $display("FAIL rstmid_busy c%0d: got %b, required %b", c, busy, exp_busy[c]); end
            n_assert++; if (fifo_wr_en !== exp_wr[c]) begin n_fail++; $display("FAIL rstmid_wr_en c%0d: got %b, required %b", c, fifo_wr_en, exp_wr[c]); end
            n_assert++; if (req_ready !== ((exp_busy[c] && tb_rst) ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL rstmid_ready c%0d: got %b", c, req_ready); end
            if (exp_busy[c] || c == 5) begin
                n_assert++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rstmid_grant c%0d: got %0d, required 0", c, grant_id); end
            end
            if (c == 5) begin
                n_assert++; if (fifo_din !== 16'h0) begin n_fail++; $display("FAIL rstmid_din c%0d: got %h, required 0000", c, fifo_din); end
            end
            if (fifo_wr_en === 1'b1) begin
                n_assert++;
                if (sb_q.size() == 0) begin n_fail++; $display("FAIL rstmid_data c%0d: unexpected write %h", c, fifo_din); end
                else begin
                    exp_d = sb_q.pop_front();
                    if (fifo_din !== exp_d) begin n_fail++; $display("FAIL rstmid_data c%0d: got %h, required %h", c, fifo_din, exp_d); end
                end
            end
        end
        tb_rst = 1'b1;
        n_assert++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL rstmid_drain: %0d beats never written, required 0", sb_q.size()); end
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        tb_rst    = 1'b0;
        tb_full   = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        test_reset();
        test_single_stream();
        test_round_robin();
        test_full_stall();
        test_owner_drop();
        test_reset_mid_burst();
        do_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
